// File: rtl/hash_msg_feeder.sv
// Buffers one byte-stream message, then plays it into the hash core (first byte 1 cycle after last beat) and captures the digest.
// in_ready is low from the end of a message until its digest is captured; overlong messages are dropped with err_overflow.
module hash_msg_feeder #(
   parameter int DEPTH = 64,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   input  logic        in_keep,
   output logic        hash_m_valid,
   output logic [7:0]  hash_message,
   output logic [63:0] hash_counter,
   input  logic        hash_ready,
   input  logic [31:0] hash_digest,
   output logic        dig_valid,
   output logic [31:0] dig_data,
   output logic        err_overflow,
   output logic        busy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [AW-1:0] ZERO_A  = '0;

   typedef enum logic [1:0] {ST_LOAD, ST_DISPATCH, ST_WAIT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] len_q, len_d;
   logic [CW-1:0] rd_q, rd_d;
   logic          ovf_q, ovf_d;
   logic          in_ready_q, in_ready_d;
   logic          busy_q, busy_d;
   logic          mv_q, mv_d;
   logic [7:0]    msg_q, msg_d;
   logic          dv_q, dv_d;
   logic [31:0]   dig_q, dig_d;
   logic          err_q, err_d;

   logic [7:0]    mem [DEPTH];
   logic          xfer, is_byte, room, wr_en;

   assign xfer    = in_valid & in_ready_q;
   assign is_byte = ~in_last | in_keep;
   assign room    = (len_q < DEPTH_C);
   assign wr_en   = xfer & is_byte & room;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[len_q[AW-1:0]] <= in_data;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      rd_d    = rd_q;
      ovf_d   = ovf_q;
      mv_d    = 1'b0;
      msg_d   = msg_q;
      dv_d    = 1'b0;
      dig_d   = dig_q;
      err_d   = 1'b0;
      case (state_q)
         ST_LOAD: begin
            if (xfer) begin
               if (is_byte) begin
                  if (room) len_d = len_q + ONE_C;
                  else      ovf_d = 1'b1;
               end
               if (in_last) begin
                  if (ovf_d) begin
                     err_d = 1'b1;
                     len_d = '0;
                     ovf_d = 1'b0;
                  end else begin
                     state_d = ST_DISPATCH;
                     rd_d    = ONE_C;
                     mv_d    = 1'b1;
                     // A one-byte message is still being written, so forward it instead of reading mem[0].
                     if (len_q != '0)  msg_d = mem[ZERO_A];
                     else if (is_byte) msg_d = in_data;
                     else              msg_d = 8'h00;
                  end
               end
            end
         end
         ST_DISPATCH: begin
            if (rd_q < len_q) begin
               mv_d  = 1'b1;
               msg_d = mem[rd_q[AW-1:0]];
               rd_d  = rd_q + ONE_C;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (hash_ready) begin
               dig_d   = hash_digest;
               dv_d    = 1'b1;
               len_d   = '0;
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
      in_ready_d = (state_d == ST_LOAD);
      busy_d     = (state_d != ST_LOAD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_LOAD;
         len_q      <= '0;
         rd_q       <= '0;
         ovf_q      <= 1'b0;
         in_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         mv_q       <= 1'b0;
         msg_q      <= 8'h00;
         dv_q       <= 1'b0;
         dig_q      <= 32'h0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         rd_q       <= rd_d;
         ovf_q      <= ovf_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         mv_q       <= mv_d;
         msg_q      <= msg_d;
         dv_q       <= dv_d;
         dig_q      <= dig_d;
         err_q      <= err_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign busy         = busy_q;
   assign hash_m_valid = mv_q;
   assign hash_message = msg_q;
   assign hash_counter = {{(64-CW){1'b0}}, len_q};
   assign dig_valid    = dv_q;
   assign dig_data     = dig_q;
   assign err_overflow = err_q;

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Bench for hash_msg_feeder: queue-based message model checked every cycle, a small hash-core responder, directed and random messages.
module tb_hash_msg_feeder;
   localparam int DEPTH = 64;
   typedef logic [7:0] u8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_last = 1'b0, in_keep = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        hash_ready = 1'b0;
   logic [31:0] hash_digest = 32'h0;
   logic        in_ready, hash_m_valid, dig_valid, err_overflow, busy;
   logic [7:0]  hash_message;
   logic [63:0] hash_counter;
   logic [31:0] dig_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hash_msg_feeder #(.DEPTH(DEPTH), .CW(7)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .in_keep(in_keep),
      .hash_m_valid(hash_m_valid), .hash_message(hash_message), .hash_counter(hash_counter),
      .hash_ready(hash_ready), .hash_digest(hash_digest),
      .dig_valid(dig_valid), .dig_data(dig_data),
      .err_overflow(err_overflow), .busy(busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Message-level model: phase 0 collecting, 1 playing out, 2 awaiting the digest.
   int          ph = 0;
   u8           mbuf[$];
   u8           dq[$];
   int          idx = 0;
   logic        e_rdy = 1'b1, e_mv = 1'b0, e_err = 1'b0, e_dv = 1'b0, e_busy = 1'b0;
   u8           e_msg = 8'h00;
   logic [63:0] e_cnt = 64'h0;
   logic [31:0] e_dig = 32'h0;

   initial forever begin
      @(posedge clk);
      e_err = 1'b0;
      e_dv  = 1'b0;
      if (rst) begin
         ph = 0;
         mbuf.delete();
         dq.delete();
         e_mv  = 1'b0;
         e_msg = 8'h00;
         e_cnt = 64'h0;
         e_dig = 32'h0;
      end else begin
         case (ph)
            0: if (in_valid) begin
               if (!in_last || in_keep) mbuf.push_back(in_data);
               if (in_last) begin
                  if (mbuf.size() > DEPTH) begin
                     e_err = 1'b1;
                     mbuf.delete();
                  end else begin
                     dq = mbuf;
                     mbuf.delete();
                     idx   = 0;
                     ph    = 1;
                     e_cnt = 64'(dq.size());
                     e_mv  = 1'b1;
                     e_msg = (dq.size() > 0) ? dq[0] : 8'h00;
                  end
               end
            end
            1: begin
               idx++;
               if (idx < dq.size()) e_msg = dq[idx];
               else begin
                  e_mv = 1'b0;
                  ph   = 2;
               end
            end
            2: if (hash_ready) begin
               e_dig = hash_digest;
               e_dv  = 1'b1;
               ph    = 0;
            end
            default: ph = 0;
         endcase
      end
      e_rdy  = (ph == 0);
      e_busy = (ph != 0);
   end

   u8           obs_bytes[$];
   logic [63:0] obs_cnts[$];
   logic [31:0] obs_digs[$];
   int          obs_err = 0;
   logic        prev_mv = 1'b0;

   initial forever begin
      @(negedge clk);
      chk("in_ready", 64'(in_ready), 64'(e_rdy));
      chk("hash_m_valid", 64'(hash_m_valid), 64'(e_mv));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("dig_valid", 64'(dig_valid), 64'(e_dv));
      chk("err_overflow", 64'(err_overflow), 64'(e_err));
      chk("dig_data", 64'(dig_data), 64'(e_dig));
      if (e_mv) chk("hash_message", 64'(hash_message), 64'(e_msg));
      if (ph != 0) chk("hash_counter", hash_counter, e_cnt);
      if (hash_m_valid) begin
         obs_bytes.push_back(hash_message);
         if (!prev_mv) obs_cnts.push_back(hash_counter);
      end
      prev_mv = hash_m_valid;
      if (dig_valid) obs_digs.push_back(dig_data);
      if (err_overflow) obs_err++;
   end

   // Hash core stand-in: drops hash_ready on the first M_valid, raises it a few cycles after the message ends.
   logic [31:0] dig_plan[$];
   initial begin
      int cd;
      logic pend;
      cd   = 0;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) pend = 1'b0;
         else if (hash_m_valid) begin
            hash_ready = 1'b0;
            pend       = 1'b1;
            cd         = int'($urandom_range(4, 0));
         end else if (pend) begin
            if (cd == 0) begin
               hash_ready  = 1'b1;
               hash_digest = (dig_plan.size() > 0) ? dig_plan.pop_front() : $urandom;
               pend        = 1'b0;
            end else cd--;
         end
      end
   end

   task automatic beat(input u8 d, input logic last, input logic keep, input int maxgap);
      int n;
      int g;
      g = int'($urandom_range(maxgap, 0));
      repeat (g) @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      in_keep  = keep;
      n = 0;
      while (in_ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL beat_accept: in_ready stayed %b for %0d cycles, required 1", in_ready, n);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_keep  = 1'($urandom);
      in_data  = 8'($urandom);
   endtask

   task automatic send_msg(input u8 b[$], input logic marker, input int maxgap);
      logic last;
      if (b.size() == 0) beat(8'hA5, 1'b1, 1'b0, maxgap);
      else begin
         for (int i = 0; i < b.size(); i++) begin
            last = (i == b.size() - 1) && !marker;
            beat(b[i], last, last ? 1'b1 : 1'($urandom), maxgap);
         end
         if (marker) beat(8'($urandom), 1'b1, 1'b0, maxgap);
      end
   endtask

   task automatic wait_digs(input int target);
      int n;
      n = 0;
      while (obs_digs.size() < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (obs_digs.size() < target) begin
         errors++;
         $display("FAIL digest_wait: got %0d digests, expected %0d", obs_digs.size(), target);
      end
   endtask

   task automatic clear_obs();
      obs_bytes.delete();
      obs_cnts.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      u8  m[$];
      int nd;
      int e0;
      int n;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_m_valid", 64'(hash_m_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_dig_valid", 64'(dig_valid), 64'd0);
      chk("rst_dig_data", 64'(dig_data), 64'd0);
      chk("rst_err", 64'(err_overflow), 64'd0);
      chk("rst_counter", hash_counter, 64'd0);
      chk("rst_message", 64'(hash_message), 64'd0);

      // "abc"
      clear_obs();
      nd = obs_digs.size();
      dig_plan.push_back(32'hDEADBEEF);
      m.delete();
      m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
      send_msg(m, 1'b0, 0);
      wait_digs(nd + 1);
      chk("abc_nbytes", 64'(obs_bytes.size()), 64'd3);
      chk("abc_b0", 64'(obs_bytes[0]), 64'h61);
      chk("abc_b1", 64'(obs_bytes[1]), 64'h62);
      chk("abc_b2", 64'(obs_bytes[2]), 64'h63);
      chk("abc_cnt", obs_cnts[0], 64'd3);
      chk("abc_digest", 64'(obs_digs[nd]), 64'hDEADBEEF);
      @(negedge clk);
      chk("abc_ready_after", 64'(in_ready), 64'd1);

      // zero-length message
      clear_obs();
      nd = obs_digs.size();
      dig_plan.push_back(32'hCAFE0001);
      m.delete();
      send_msg(m, 1'b0, 0);
      wait_digs(nd + 1);
      chk("zero_nbytes", 64'(obs_bytes.size()), 64'd1);
      chk("zero_byte", 64'(obs_bytes[0]), 64'h00);
      chk("zero_cnt", obs_cnts[0], 64'd0);
      chk("zero_digest", 64'(obs_digs[nd]), 64'hCAFE0001);

      // exactly DEPTH bytes
      clear_obs();
      nd = obs_digs.size();
      e0 = obs_err;
      m.delete();
      for (int i = 0; i < DEPTH; i++) m.push_back(8'(i));
      send_msg(m, 1'b0, 0);
      wait_digs(nd + 1);
      chk("full_nbytes", 64'(obs_bytes.size()), 64'd64);
      chk("full_first", 64'(obs_bytes[0]), 64'h00);
      chk("full_last", 64'(obs_bytes[63]), 64'h3F);
      chk("full_cnt", obs_cnts[0], 64'd64);
      chk("full_no_err", 64'(obs_err), 64'(e0));

      // DEPTH+1 bytes
      clear_obs();
      e0 = obs_err;
      m.push_back(8'h40);
      send_msg(m, 1'b0, 0);
      repeat (3) @(negedge clk);
      chk("ovf_err", 64'(obs_err), 64'(e0 + 1));
      chk("ovf_no_valid", 64'(obs_bytes.size()), 64'd0);
      chk("ovf_ready", 64'(in_ready), 64'd1);
      chk("ovf_busy", 64'(busy), 64'd0);

      // back-to-back "a" then "bc"
      clear_obs();
      nd = obs_digs.size();
      m.delete(); m.push_back(8'h61);
      send_msg(m, 1'b0, 0);
      m.delete(); m.push_back(8'h62); m.push_back(8'h63);
      send_msg(m, 1'b0, 0);
      wait_digs(nd + 2);
      chk("b2b_nbytes", 64'(obs_bytes.size()), 64'd3);
      chk("b2b_cnt_a", obs_cnts[0], 64'd1);
      chk("b2b_cnt_bc", obs_cnts[1], 64'd2);
      chk("b2b_byte_b", 64'(obs_bytes[1]), 64'h62);

      // reset during the second cycle of a 5-byte dispatch
      clear_obs();
      m.delete();
      for (int i = 1; i <= 5; i++) m.push_back(8'(i));
      send_msg(m, 1'b0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rstd_m_valid", 64'(hash_m_valid), 64'd0);
      chk("rstd_in_ready", 64'(in_ready), 64'd1);
      chk("rstd_busy", 64'(busy), 64'd0);
      chk("rstd_nbytes", 64'(obs_bytes.size()), 64'd2);
      @(negedge clk);
      rst = 1'b0;
      clear_obs();
      nd = obs_digs.size();
      dig_plan.push_back(32'h7A7A0001);
      m.delete(); m.push_back(8'h7A);
      send_msg(m, 1'b0, 0);
      wait_digs(nd + 1);
      chk("post_rst_byte", 64'(obs_bytes[0]), 64'h7A);
      chk("post_rst_cnt", obs_cnts[0], 64'd1);
      chk("post_rst_digest", 64'(obs_digs[nd]), 64'h7A7A0001);

      // idle gap between input beats
      clear_obs();
      nd = obs_digs.size();
      beat(8'h10, 1'b0, 1'b0, 0);
      @(negedge clk);
      beat(8'h20, 1'b1, 1'b1, 0);
      wait_digs(nd + 1);
      chk("gap_nbytes", 64'(obs_bytes.size()), 64'd2);
      chk("gap_b0", 64'(obs_bytes[0]), 64'h10);
      chk("gap_b1", 64'(obs_bytes[1]), 64'h20);
      chk("gap_cnt", obs_cnts[0], 64'd2);

      // random traffic, including lengths around DEPTH and trailing marker beats
      for (int t = 0; t < 40; t++) begin
         int len;
         len = ($urandom_range(9, 0) == 0) ? int'($urandom_range(70, 60)) : int'($urandom_range(12, 0));
         m.delete();
         for (int i = 0; i < len; i++) m.push_back(8'($urandom));
         send_msg(m, ($urandom_range(3, 0) == 0), 2);
      end
      n = 0;
      while ((ph != 0 || in_ready !== 1'b1) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("final_idle", 64'(in_ready), 64'd1);
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
